rf_write_arbiter: RTL and testbench

//  Shares the register file's single write port between two requesters.

---
 rtl/rf_write_arbiter_pkg.sv | 27 ++
 rtl/rf_write_arbiter_fifo.sv | 95 +++++++++
 rtl/rf_write_arbiter.sv | 130 +++++++++++++
 tb/tb_rf_write_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter.
package rf_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  // Which requester owns the write port this cycle.
  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_A    = 2'd1,
    GRANT_B    = 2'd2
  } grant_e;

  // One-hot register mask; x0 never appears because it is hard-wired to zero.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] v;
    v = '0;
    if (addr != REG_X0) begin
      v[addr] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_fifo.sv
// Small synchronous FIFO holding long-latency results until the write port is free.
// Head fields are visible combinationally so the arbiter can grant in the same cycle;
// per-entry valid/address vectors feed the pending-destination mask.
module rf_wb_fifo
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 push_i,
  input  logic [REG_ADDR_W-1:0]                push_addr_i,
  input  logic [XLEN-1:0]                      push_data_i,
  input  logic                                 pop_i,
  output logic [REG_ADDR_W-1:0]                head_addr_o,
  output logic [XLEN-1:0]                      head_data_o,
  output logic                                 full_o,
  output logic                                 empty_o,
  output logic [DEPTH-1:0]                     entry_valid_o,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]     entry_addr_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [REG_ADDR_W-1:0] addr_mem [DEPTH];
  logic [XLEN-1:0]       data_mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_addr_o = addr_mem[rd_ptr_q];
  assign head_data_o = data_mem[rd_ptr_q];

  // Pointer and occupancy next state; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Per-slot valid flags: the popped slot clears and the pushed slot sets at the same edge.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign valid_d[gi] = (valid_q[gi] && !(do_pop && rd_ptr_q == PTR_W'(gi)))
                         || (do_push && wr_ptr_q == PTR_W'(gi));
      assign entry_valid_o[gi] = valid_q[gi];
      assign entry_addr_o[gi]  = addr_mem[gi];
    end
  endgenerate

  // Control state; reset discards every buffered entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage; contents are qualified by valid_q so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr_q] <= push_addr_i;
      data_mem[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port between the writeback stage (A) and
// a long-latency unit (B). B results are buffered and drained when A is idle, when
// the head has starved, or when the head must land before a younger A write to the
// same register. Exports a mask of destinations still waiting in the buffer.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [XLEN-1:0]       a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [XLEN-1:0]       b_data,
  output logic                  b_ready,
  output logic                  write_en,
  output logic [REG_ADDR_W-1:0] write_addr,
  output logic [XLEN-1:0]       write_value,
  output logic [NUM_REGS-1:0]   pend_mask
);

  localparam int               STARVE_W   = 4;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [REG_ADDR_W-1:0]                head_addr;
  logic [XLEN-1:0]                      head_data;
  logic                                 fifo_full;
  logic                                 fifo_empty;
  logic [FIFO_DEPTH-1:0]                entry_valid;
  logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] entry_addr;

  logic          hv;
  grant_e        grant;
  logic [STARVE_W-1:0] starve_q, starve_d;

  rf_wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (b_valid && b_ready),
    .push_addr_i  (b_addr),
    .push_data_i  (b_data),
    .pop_i        (grant == GRANT_B),
    .head_addr_o  (head_addr),
    .head_data_o  (head_data),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .entry_valid_o(entry_valid),
    .entry_addr_o (entry_addr)
  );

  assign hv = !fifo_empty;

  // Fixed-priority grant: starved head, then older same-destination head, then A, then B.
  always_comb begin
    grant = GRANT_NONE;
    if (reset) begin
      grant = GRANT_NONE;
    end else if (hv && starve_q == STARVE_MAX) begin
      grant = GRANT_B;
    end else if (hv && a_valid && head_addr == a_addr && a_addr != REG_X0) begin
      grant = GRANT_B;
    end else if (a_valid) begin
      grant = GRANT_A;
    end else if (hv) begin
      grant = GRANT_B;
    end
  end

  // Output mux to the register file; x0 writes complete their handshake but stay off the port.
  always_comb begin
    write_addr  = '0;
    write_value = '0;
    case (grant)
      GRANT_A: begin
        write_addr  = a_addr;
        write_value = a_data;
      end
      GRANT_B: begin
        write_addr  = head_addr;
        write_value = head_data;
      end
      default: begin
        write_addr  = '0;
        write_value = '0;
      end
    endcase
    write_en = (grant != GRANT_NONE) && (write_addr != REG_X0);
  end

  assign a_ready = !((grant == GRANT_B) && a_valid);
  // Full-based only, so a same-cycle pop never creates a ready->valid combinational path.
  assign b_ready = !fifo_full && !reset;

  // Starvation counter: counts cycles the head loses, saturating at the limit.
  always_comb begin
    starve_d = starve_q;
    if (grant == GRANT_B || !hv) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Pending-destination mask built from the FIFO's registered slot state.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_valid[i]) begin
        pend_mask = pend_mask | reg_onehot(entry_addr[i]);
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model of the arbitration rules.
module tb_rf_write_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_value;
  logic [31:0] pend_mask;

  int errors = 0;
  int checks = 0;

  logic [31:0] rf_model [32];

  rf_write_arbiter #(
    .FIFO_DEPTH  (DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .a_valid    (a_valid),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_value(write_value),
    .pend_mask  (pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: commits whatever the port presents at each edge.
  always @(posedge clk) begin
    if (write_en) rf_model[write_addr] <= write_value;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  task automatic drive_idle();
    a_valid = 1'b0; a_addr = 5'd0; a_data = 32'd0;
    b_valid = 1'b0; b_addr = 5'd0; b_data = 32'd0;
  endtask

  task automatic test_reset();
    // Held in reset from time 0 with both requesters active.
    a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h55;
    b_valid = 1'b1; b_addr = 5'd8; b_data = 32'h66;
    @(negedge clk);
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", write_en); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset_bready: got %b want 0", b_ready); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_aready: got %b want 1", a_ready); end
    checks++; if (pend_mask !== 32'd0) begin errors++; $display("FAIL reset_mask: got %h want 0", pend_mask); end
    @(posedge clk); #1;
    reset = 1'b0; a_valid = 1'b0;
    @(negedge clk);
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL release_bready: got %b want 1", b_ready); end
    @(posedge clk); #1;          // x8 pushed at this edge
    b_valid = 1'b0;
    @(negedge clk);
    checks++; if (pend_mask !== 32'h100) begin errors++; $display("FAIL pre_reset_mask: got %h want 00000100", pend_mask); end
    #2 reset = 1'b1;             // mid-cycle assertion
    #1;
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL midreset_we: got %b want 0", write_en); end
    checks++; if (pend_mask !== 32'd0) begin errors++; $display("FAIL midreset_mask: got %h want 0", pend_mask); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL midreset_bready: got %b want 0", b_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL postreset_bready: got %b want 1", b_ready); end
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL postreset_discard: got we=%b want 0", write_en); end
    $display("test_reset done: errors=%0d", errors);
  endtask

  task automatic test_a_only();
    @(posedge clk); #1;
    drive_idle();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h11;
    @(negedge clk);
    checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL aonly_we: got %b want 1", write_en); end
    checks++; if (write_addr !== 5'd5) begin errors++; $display("FAIL aonly_addr: got %0d want 5", write_addr); end
    checks++; if (write_value !== 32'h11) begin errors++; $display("FAIL aonly_value: got %h want 11", write_value); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL aonly_aready: got %b want 1", a_ready); end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    checks++; if ({write_en, write_addr, write_value} !== 38'd0) begin
      errors++; $display("FAIL idle_zero: got we=%b addr=%0d val=%h want all 0", write_en, write_addr, write_value);
    end
    $display("test_a_only done: errors=%0d", errors);
  endtask

  task automatic test_b_drain();
    @(posedge clk); #1;
    drive_idle();
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hAA;
    @(negedge clk);
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL drain_noflow: got we=%b want 0", write_en); end
    @(posedge clk); #1;
    b_valid = 1'b0;
    @(negedge clk);
    checks++; if (write_en !== 1'b1 || write_addr !== 5'd7 || write_value !== 32'hAA) begin
      errors++; $display("FAIL drain_write: got we=%b addr=%0d val=%h want 1/7/aa", write_en, write_addr, write_value);
    end
    checks++; if (pend_mask !== 32'h80) begin errors++; $display("FAIL drain_mask: got %h want 00000080", pend_mask); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (pend_mask !== 32'd0 || write_en !== 1'b0) begin
      errors++; $display("FAIL drain_after: got mask=%h we=%b want 0/0", pend_mask, write_en);
    end
    $display("test_b_drain done: errors=%0d", errors);
  endtask

  task automatic test_starvation();
    @(posedge clk); #1;
    drive_idle();
    a_valid = 1'b1; a_addr = 5'd4; a_data = 32'd100;
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h99;
    @(negedge clk);
    checks++; if (write_addr !== 5'd4 || a_ready !== 1'b1) begin
      errors++; $display("FAIL starve_push: got addr=%0d ardy=%b want 4/1", write_addr, a_ready);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      b_valid = 1'b0;
      a_addr = 5'(16 + k); a_data = 32'(200 + k);
      @(negedge clk);
      checks++; if (write_addr !== 5'(16 + k) || a_ready !== 1'b1 || pend_mask !== 32'h200) begin
        errors++; $display("FAIL starve_a%0d: got addr=%0d ardy=%b mask=%h want %0d/1/00000200",
                           k, write_addr, a_ready, pend_mask, 16 + k);
      end
    end
    @(posedge clk); #1;
    a_addr = 5'd20; a_data = 32'd300;
    @(negedge clk);
    checks++; if (write_en !== 1'b1 || write_addr !== 5'd9 || write_value !== 32'h99 || a_ready !== 1'b0) begin
      errors++; $display("FAIL starve_force: got we=%b addr=%0d val=%h ardy=%b want 1/9/99/0",
                         write_en, write_addr, write_value, a_ready);
    end
    @(posedge clk); #1;          // A held stable
    @(negedge clk);
    checks++; if (write_addr !== 5'd20 || write_value !== 32'd300 || a_ready !== 1'b1 || pend_mask !== 32'd0) begin
      errors++; $display("FAIL starve_a_lands: got addr=%0d val=%0d ardy=%b mask=%h want 20/300/1/0",
                         write_addr, write_value, a_ready, pend_mask);
    end
    $display("test_starvation done: errors=%0d", errors);
  endtask

  task automatic test_same_addr();
    @(posedge clk); #1;
    drive_idle();
    a_valid = 1'b1; a_addr = 5'd10; a_data = 32'h10;
    b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h1;
    @(negedge clk);
    @(posedge clk); #1;
    b_valid = 1'b0;
    a_addr = 5'd3; a_data = 32'h2;
    @(negedge clk);
    checks++; if (write_addr !== 5'd3 || write_value !== 32'h1 || a_ready !== 1'b0) begin
      errors++; $display("FAIL same_old_first: got addr=%0d val=%h ardy=%b want 3/1/0", write_addr, write_value, a_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (write_addr !== 5'd3 || write_value !== 32'h2 || a_ready !== 1'b1) begin
      errors++; $display("FAIL same_young_next: got addr=%0d val=%h ardy=%b want 3/2/1", write_addr, write_value, a_ready);
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    checks++; if (rf_model[3] !== 32'h2) begin errors++; $display("FAIL same_final_x3: got %h want 2", rf_model[3]); end
    $display("test_same_addr done: errors=%0d", errors);
  endtask

  task automatic test_x0_full();
    @(posedge clk); #1;
    drive_idle();
    a_valid = 1'b1; a_addr = 5'd12; a_data = 32'hC0;
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hDEAD;
    @(negedge clk);
    @(posedge clk); #1;
    a_data = 32'hC1; b_addr = 5'd11; b_data = 32'hB11;
    @(negedge clk);
    checks++; if (write_addr !== 5'd12 || pend_mask !== 32'd0) begin
      errors++; $display("FAIL x0_mask: got addr=%0d mask=%h want 12/0", write_addr, pend_mask);
    end
    @(posedge clk); #1;
    a_data = 32'hC2; b_addr = 5'd13; b_data = 32'hB13;
    @(negedge clk);
    checks++; if (b_ready !== 1'b0 || pend_mask !== 32'h800) begin
      errors++; $display("FAIL full_bready: got brdy=%b mask=%h want 0/00000800", b_ready, pend_mask);
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    checks++; if (write_en !== 1'b0 || a_ready !== 1'b1 || pend_mask[0] !== 1'b0 || b_ready !== 1'b0) begin
      errors++; $display("FAIL x0_pop: got we=%b ardy=%b mask=%h brdy=%b want 0/1/bit0=0/0",
                         write_en, a_ready, pend_mask, b_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (write_en !== 1'b1 || write_addr !== 5'd11 || write_value !== 32'hB11 || b_ready !== 1'b1) begin
      errors++; $display("FAIL x11_pop: got we=%b addr=%0d val=%h brdy=%b want 1/11/b11/1",
                         write_en, write_addr, write_value, b_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (write_en !== 1'b0 || pend_mask !== 32'd0) begin
      errors++; $display("FAIL full_nopush: got we=%b mask=%h want 0/0", write_en, pend_mask);
    end
    $display("test_x0_full done: errors=%0d", errors);
  endtask

  task automatic test_random();
    logic [4:0]  qa[$];
    logic [31:0] qd[$];
    int          starve;
    logic        hold_a;
    logic        hv, gb, ga, e_we, e_ardy, e_brdy;
    logic [4:0]  e_addr;
    logic [31:0] e_val, e_mask;

    @(posedge clk); #1;
    drive_idle();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    starve = 0;
    hold_a = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(posedge clk); #1;
      if (!hold_a) begin
        a_valid = ($urandom_range(0, 99) < 60);
        a_addr  = 5'($urandom_range(0, 7));
        a_data  = $urandom;
      end
      b_valid = ($urandom_range(0, 99) < 45);
      b_addr  = 5'($urandom_range(0, 7));
      b_data  = $urandom;
      @(negedge clk);

      hv = (qa.size() > 0);
      e_brdy = (qa.size() < DEPTH);
      gb = 1'b0; ga = 1'b0;
      if (hv && starve == LIMIT) gb = 1'b1;
      else if (hv && a_valid && qa[0] == a_addr && a_addr != 0) gb = 1'b1;
      else if (a_valid) ga = 1'b1;
      else if (hv) gb = 1'b1;
      e_addr = gb ? qa[0] : (ga ? a_addr : 5'd0);
      e_val  = gb ? qd[0] : (ga ? a_data : 32'd0);
      e_we   = (ga || gb) && (e_addr != 0);
      e_ardy = !(gb && a_valid);
      e_mask = 32'd0;
      foreach (qa[i]) e_mask = e_mask | (32'd1 << qa[i]);
      e_mask[0] = 1'b0;

      checks++;
      if (write_en !== e_we || write_addr !== e_addr || write_value !== e_val ||
          a_ready !== e_ardy || b_ready !== e_brdy || pend_mask !== e_mask) begin
        errors++;
        $display("FAIL rand_c%0d: got we=%b addr=%0d val=%h ardy=%b brdy=%b mask=%h want %b/%0d/%h/%b/%b/%h",
                 cyc, write_en, write_addr, write_value, a_ready, b_ready, pend_mask,
                 e_we, e_addr, e_val, e_ardy, e_brdy, e_mask);
      end

      if (gb) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
      if (b_valid && e_brdy) begin
        qa.push_back(b_addr);
        qd.push_back(b_data);
      end
      if (gb || !hv) starve = 0;
      else if (starve < LIMIT) starve++;
      hold_a = a_valid && !e_ardy;
    end
    @(posedge clk); #1;
    drive_idle();
    $display("test_random done: errors=%0d", errors);
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_a_only();
    test_b_drain();
    test_starvation();
    test_same_addr();
    test_x0_full();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
